// File: rtl/m68k_bus_ctrl_if.sv
// m68k_bus_ctrl_if: 68000 bus-cycle signals between the CPU side (master)
// and the bus-cycle controller (slave).
//   CPU -> controller : as_n, uds_n, lds_n, read, addr[23:0], fc[2:0]
//   device -> ctrl    : io_ready (carried here so one bundle covers the bus)
//   controller -> CPU : dtack_n, berr_n, vpa_n
//   controller -> dev : rom_cs_n, ram_cs_n, io_cs_n, oe_n, we_hi_n, we_lo_n
interface m68k_bus_ctrl_if;
  logic        as_n;
  logic        uds_n;
  logic        lds_n;
  logic        read;
  logic [23:0] addr;
  logic [2:0]  fc;
  logic        io_ready;
  logic        dtack_n;
  logic        berr_n;
  logic        vpa_n;
  logic        rom_cs_n;
  logic        ram_cs_n;
  logic        io_cs_n;
  logic        oe_n;
  logic        we_hi_n;
  logic        we_lo_n;

  modport master (
    output as_n, uds_n, lds_n, read, addr, fc, io_ready,
    input  dtack_n, berr_n, vpa_n, rom_cs_n, ram_cs_n, io_cs_n,
           oe_n, we_hi_n, we_lo_n
  );

  modport slave (
    input  as_n, uds_n, lds_n, read, addr, fc, io_ready,
    output dtack_n, berr_n, vpa_n, rom_cs_n, ram_cs_n, io_cs_n,
           oe_n, we_hi_n, we_lo_n
  );
endinterface

// File: rtl/m68k_bus_ctrl.sv
// m68k_bus_ctrl: 68000 bus-cycle controller. Synchronizes AS, decodes the
// address/function code into ROM (0x0xxxxx), RAM (0x1xxxxx) or IO (0xFxxxxx),
// asserts the chip select and strobes, inserts per-region wait states and
// terminates the cycle with DTACK, VPA (autovector IACK) or BERR (unmapped,
// ROM write, watchdog timeout).
// Ports:
//   clk   : system clock (same clock as the CPU)
//   reset : synchronous, active-high
//   bus   : m68k_bus_ctrl_if.slave (CPU pins, io_ready, selects and strobes)
// All outputs are registered, active-low, and high while idle.
module m68k_bus_ctrl #(
  parameter int ROM_WAIT       = 2,
  parameter int RAM_WAIT       = 0,
  parameter int IO_WAIT        = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  m68k_bus_ctrl_if.slave   bus
);
  localparam int MAX_WAIT = (ROM_WAIT > RAM_WAIT)
                          ? ((ROM_WAIT > IO_WAIT) ? ROM_WAIT : IO_WAIT)
                          : ((RAM_WAIT > IO_WAIT) ? RAM_WAIT : IO_WAIT);
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT, S_ACK, S_VPA, S_ERR
  } state_t;

  typedef enum logic [1:0] {R_NONE, R_ROM, R_RAM, R_IO} region_t;

  typedef struct packed {
    logic dtack_n;
    logic berr_n;
    logic vpa_n;
    logic rom_cs_n;
    logic ram_cs_n;
    logic io_cs_n;
    logic oe_n;
    logic we_hi_n;
    logic we_lo_n;
  } outs_t;

  state_t        state;
  region_t       region_l;
  region_t       region_dec;
  logic [CW-1:0] region_wait;
  logic [CW-1:0] wait_cnt;
  logic [DW-1:0] wdog;
  logic          as_meta;
  logic          as_sync;
  outs_t         o;
  logic          unused_addr;

  // Only the top nibble selects a region; byte offsets are the devices' business.
  assign unused_addr = ^bus.addr[19:0];

  always_comb begin
    region_dec = R_NONE;
    unique case (bus.addr[23:20])
      4'h0:    region_dec = R_ROM;
      4'h1:    region_dec = R_RAM;
      4'hF:    region_dec = R_IO;
      default: region_dec = R_NONE;
    endcase
  end

  always_comb begin
    region_wait = '0;
    unique case (region_dec)
      R_ROM:   region_wait = CW'(ROM_WAIT);
      R_RAM:   region_wait = CW'(RAM_WAIT);
      R_IO:    region_wait = CW'(IO_WAIT);
      default: region_wait = '0;
    endcase
  end

  // Outputs are updated on the same edge as the state they belong to, so the
  // output flops themselves hold the latched read/uds/lds values during WAIT
  // and ACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      as_meta  <= 1'b0;
      as_sync  <= 1'b0;
      state    <= S_IDLE;
      region_l <= R_NONE;
      wait_cnt <= '0;
      wdog     <= '0;
      o        <= '1;
    end else begin
      // AS synchronizer stage boundary: as_n -> as_meta -> as_sync
      as_meta <= ~bus.as_n;
      as_sync <= as_meta;

      unique case (state)
        S_IDLE: begin
          if (as_sync) state <= S_DECODE;
        end

        S_DECODE: begin
          if (!as_sync) begin
            state <= S_IDLE;
          end else if (bus.fc == 3'b111) begin
            state   <= S_VPA;
            o.vpa_n <= 1'b0;
          end else if (region_dec == R_NONE || (region_dec == R_ROM && !bus.read)) begin
            state    <= S_ERR;
            o.berr_n <= 1'b0;
          end else begin
            state      <= S_WAIT;
            region_l   <= region_dec;
            wait_cnt   <= region_wait;
            wdog       <= '0;
            o.rom_cs_n <= (region_dec != R_ROM);
            o.ram_cs_n <= (region_dec != R_RAM);
            o.io_cs_n  <= (region_dec != R_IO);
            o.oe_n     <= ~bus.read;
            o.we_hi_n  <= bus.read | bus.uds_n;
            o.we_lo_n  <= bus.read | bus.lds_n;
          end
        end

        S_WAIT: begin
          if (!as_sync) begin
            state <= S_IDLE;
            o     <= '1;
          end else if (wait_cnt == '0 && (region_l != R_IO || bus.io_ready)) begin
            // Termination is tested before the watchdog so ACK wins a tie.
            state     <= S_ACK;
            o.dtack_n <= 1'b0;
          end else begin
            if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
            wdog <= wdog + 1'b1;
            if (wdog == DW'(TIMEOUT_CYCLES - 1)) begin
              state    <= S_ERR;
              o        <= '1;
              o.berr_n <= 1'b0;
            end
          end
        end

        S_ACK, S_VPA, S_ERR: begin
          if (!as_sync) begin
            state <= S_IDLE;
            o     <= '1;
          end
        end

        default: begin
          state <= S_IDLE;
          o     <= '1;
        end
      endcase
    end
  end

  assign bus.dtack_n  = o.dtack_n;
  assign bus.berr_n   = o.berr_n;
  assign bus.vpa_n    = o.vpa_n;
  assign bus.rom_cs_n = o.rom_cs_n;
  assign bus.ram_cs_n = o.ram_cs_n;
  assign bus.io_cs_n  = o.io_cs_n;
  assign bus.oe_n     = o.oe_n;
  assign bus.we_hi_n  = o.we_hi_n;
  assign bus.we_lo_n  = o.we_lo_n;
endmodule
